// File: rtl/ram64x8_bist.sv
// March C- self-test engine for a 64x8 RAM with combinational read.
// Drives wen/addr/din from registered state only and checks dout at each read edge.
module ram64x8_bist #(
    parameter logic [7:0] BG           = 8'h00,
    parameter bit         STOP_ON_FAIL = 1'b1
) (
    input  logic       ck,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_addr,
    output logic [7:0] fail_data,
    output logic       ram_wen,
    output logic [5:0] ram_addr,
    output logic [7:0] ram_din,
    input  logic [7:0] ram_dout
);

    // state  | meaning
    // S_IDLE | waiting for start, results cleared
    // S_RUN  | one march op per cycle (element r_elem, address r_addr, r_wr = write half)
    // S_DONE | results held until the next accepted start
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_elem;
    logic [5:0] r_addr;
    logic       r_wr;
    logic       r_failed;
    logic       r_pass;
    logic [5:0] r_fail_addr;
    logic [7:0] r_fail_data;

    logic       w_run;
    logic       w_single;
    logic       w_is_write;
    logic       w_up;
    logic       w_next_up;
    logic       w_wr_one;
    logic       w_rd_one;
    logic [7:0] w_wr_data;
    logic [7:0] w_rd_exp;
    logic       w_mismatch;
    logic       w_last_op;
    logic       w_elem_end;
    logic [2:0] w_elem_nxt;

    // M0 and M5 carry a single op; M1..M4 alternate read then write per address.
    always_comb begin
        w_run      = (r_state == S_RUN);
        w_single   = (r_elem == 3'd0) || (r_elem == 3'd5);
        w_is_write = (r_elem == 3'd0) || (!w_single && r_wr);
        w_up       = (r_elem != 3'd3) && (r_elem != 3'd4);
        w_elem_nxt = r_elem + 3'd1;
        w_next_up  = (w_elem_nxt != 3'd3) && (w_elem_nxt != 3'd4);
        w_wr_one   = (r_elem == 3'd1) || (r_elem == 3'd3);
        w_rd_one   = (r_elem == 3'd2) || (r_elem == 3'd4);
        w_wr_data  = w_wr_one ? ~BG : BG;
        w_rd_exp   = w_rd_one ? ~BG : BG;
        w_mismatch = w_run && !w_is_write && (ram_dout != w_rd_exp);
        w_last_op  = (r_elem == 3'd5) && (r_addr == 6'd63);
        w_elem_end = (w_single || r_wr) && (r_addr == (w_up ? 6'd63 : 6'd0));
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_elem      <= 3'd0;
            r_addr      <= 6'd0;
            r_wr        <= 1'b0;
            r_failed    <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= 6'd0;
            r_fail_data <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        r_elem      <= 3'd0;
                        r_addr      <= 6'd0;
                        r_wr        <= 1'b0;
                        r_failed    <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_addr <= 6'd0;
                        r_fail_data <= 8'd0;
                    end
                end
                S_RUN: begin
                    if (w_mismatch && !r_failed) begin
                        r_failed    <= 1'b1;
                        r_fail_addr <= r_addr;
                        r_fail_data <= ram_dout;
                    end
                    if (w_last_op || (w_mismatch && STOP_ON_FAIL)) begin
                        r_state <= S_DONE;
                        r_wr    <= 1'b0;
                        r_pass  <= !(r_failed || w_mismatch);
                    end else if (!w_single && !r_wr) begin
                        r_wr <= 1'b1;
                    end else begin
                        r_wr <= 1'b0;
                        if (w_elem_end) begin
                            r_elem <= w_elem_nxt;
                            r_addr <= w_next_up ? 6'd0 : 6'd63;
                        end else begin
                            r_addr <= w_up ? (r_addr + 6'd1) : (r_addr - 6'd1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = w_run;
        done      = (r_state == S_DONE);
        pass      = r_pass;
        fail_addr = r_fail_addr;
        fail_data = r_fail_data;
        ram_wen   = w_run && w_is_write;
        ram_addr  = r_addr;
        ram_din   = (w_run && w_is_write) ? w_wr_data : 8'h00;
    end

endmodule

// File: tb/tb_ram64x8_bist.sv
// Bench for ram64x8_bist: two instances (stop-on-fail and full-march) each with a
// faultable RAM model; completions are checked by a scoreboard monitor.
module tb_ram64x8_bist;

    typedef struct {
        int pass;
        int fa;
        int fd;
        int busy;
        int wen;
    } exp_t;

    logic ck = 1'b0;
    always #5 ck = ~ck;

    logic       rst_v   [2];
    logic       start_v [2];
    logic       busy_v  [2];
    logic       done_v  [2];
    logic       pass_v  [2];
    logic [5:0] fa_v    [2];
    logic [7:0] fd_v    [2];
    logic       wen_v   [2];
    logic [5:0] addr_v  [2];
    logic [7:0] din_v   [2];
    logic [7:0] dout_v  [2];

    logic [7:0] sa1_mask  [2][64];
    logic       alias_on  [2];
    logic [5:0] alias_src [2];
    logic [5:0] alias_dst [2];

    exp_t sb_q [2][$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int p, input int fa, input int fd, input int b, input int w);
        exp_t e;
        e.pass = p; e.fa = fa; e.fd = fd; e.busy = b; e.wen = w;
        return e;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] mem [64];
        int   busy_cnt = 0;
        int   wen_cnt  = 0;
        logic busy_d   = 1'b0;
        logic done_d   = 1'b0;
        exp_t e;

        ram64x8_bist #(.BG(8'h00), .STOP_ON_FAIL(g == 0)) u_dut (
            .ck       (ck),
            .rst      (rst_v[g]),
            .start    (start_v[g]),
            .busy     (busy_v[g]),
            .done     (done_v[g]),
            .pass     (pass_v[g]),
            .fail_addr(fa_v[g]),
            .fail_data(fd_v[g]),
            .ram_wen  (wen_v[g]),
            .ram_addr (addr_v[g]),
            .ram_din  (din_v[g]),
            .ram_dout (dout_v[g])
        );

        always @(posedge ck) begin
            if (wen_v[g]) begin
                mem[addr_v[g]] <= din_v[g];
                if (alias_on[g] && addr_v[g] == alias_src[g])
                    mem[alias_dst[g]] <= din_v[g];
            end
        end

        assign dout_v[g] = mem[addr_v[g]] | sa1_mask[g][addr_v[g]];

        always @(negedge ck) begin
            if (busy_v[g] && !busy_d) begin
                busy_cnt = 0;
                wen_cnt  = 0;
            end
            if (busy_v[g]) busy_cnt++;
            if (wen_v[g]) wen_cnt++;
            if (done_v[g] && !done_d) begin
                chk($sformatf("d%0d_sb_pending", g), int'(sb_q[g].size() > 0), 1);
                if (sb_q[g].size() > 0) begin
                    e = sb_q[g].pop_front();
                    chk($sformatf("d%0d_pass", g), int'(pass_v[g]), e.pass);
                    chk($sformatf("d%0d_fail_addr", g), int'(fa_v[g]), e.fa);
                    chk($sformatf("d%0d_fail_data", g), int'(fd_v[g]), e.fd);
                    chk($sformatf("d%0d_busy_cycles", g), busy_cnt, e.busy);
                    chk($sformatf("d%0d_wen_cycles", g), wen_cnt, e.wen);
                end
            end
            busy_d = busy_v[g];
            done_d = done_v[g];
        end
    end

    task automatic step();
        @(posedge ck);
        #1;
    endtask

    task automatic clear_faults(input int g);
        for (int i = 0; i < 64; i++) sa1_mask[g][i] = 8'h00;
        alias_on[g]  = 1'b0;
        alias_src[g] = 6'd0;
        alias_dst[g] = 6'd0;
    endtask

    task automatic check_idle(input int g, input string tag);
        chk({tag, "_busy"}, int'(busy_v[g]), 0);
        chk({tag, "_done"}, int'(done_v[g]), 0);
        chk({tag, "_pass"}, int'(pass_v[g]), 0);
        chk({tag, "_fail_addr"}, int'(fa_v[g]), 0);
        chk({tag, "_fail_data"}, int'(fd_v[g]), 0);
        chk({tag, "_ram_wen"}, int'(wen_v[g]), 0);
        chk({tag, "_ram_addr"}, int'(addr_v[g]), 0);
        chk({tag, "_ram_din"}, int'(din_v[g]), 0);
    endtask

    task automatic pulse_start(input int g, input exp_t e);
        sb_q[g].push_back(e);
        start_v[g] = 1'b1;
        step();
        start_v[g] = 1'b0;
        chk($sformatf("d%0d_busy_after_start", g), int'(busy_v[g]), 1);
        chk($sformatf("d%0d_done_cleared", g), int'(done_v[g]), 0);
        chk($sformatf("d%0d_fail_addr_cleared", g), int'(fa_v[g]), 0);
        chk($sformatf("d%0d_fail_data_cleared", g), int'(fd_v[g]), 0);
        chk($sformatf("d%0d_pass_cleared", g), int'(pass_v[g]), 0);
    endtask

    task automatic wait_done(input int g);
        int n = 0;
        while (!done_v[g] && n < 1000) begin
            step();
            n++;
        end
        chk($sformatf("d%0d_done_within_bound", g), int'(done_v[g]), 1);
        step();
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            rst_v[g]   = 1'b1;
            start_v[g] = 1'b0;
            clear_faults(g);
        end
        repeat (3) step();
        rst_v[0] = 1'b0;
        rst_v[1] = 1'b0;
        check_idle(0, "d0_reset");
        check_idle(1, "d1_reset");

        // Clean runs on both instances.
        pulse_start(1, mk(1, 0, 0, 640, 320));
        wait_done(1);
        pulse_start(0, mk(1, 0, 0, 640, 320));
        wait_done(0);

        // Bit0 stuck-at-1 at 0x25, stop on first miscompare (M1 read of 0x25).
        sa1_mask[0][37] = 8'h01;
        pulse_start(0, mk(0, 37, 1, 139, 101));
        wait_done(0);

        // Done must hold, then a restart clears the failure results.
        clear_faults(0);
        repeat (4) step();
        chk("d0_done_held", int'(done_v[0]), 1);
        chk("d0_fail_addr_held", int'(fa_v[0]), 37);
        pulse_start(0, mk(1, 0, 0, 640, 320));
        wait_done(0);

        // Decode fault: writing 0x05 also writes 0x15.
        alias_on[0]  = 1'b1;
        alias_src[0] = 6'h05;
        alias_dst[0] = 6'h15;
        pulse_start(0, mk(0, 21, 255, 107, 85));
        wait_done(0);
        clear_faults(0);

        // Full march with two faults: first one recorded.
        sa1_mask[1][3]  = 8'h01;
        sa1_mask[1][48] = 8'h01;
        pulse_start(1, mk(0, 3, 1, 640, 320));
        wait_done(1);
        clear_faults(1);

        // Reset at op 300 aborts the run; a fresh start then runs clean.
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        repeat (300) step();
        rst_v[1] = 1'b1;
        step();
        rst_v[1] = 1'b0;
        check_idle(1, "d1_midrun_rst");
        step();
        pulse_start(1, mk(1, 0, 0, 640, 320));
        wait_done(1);

        // Start held high through the run is ignored.
        sb_q[0].push_back(mk(1, 0, 0, 640, 320));
        start_v[0] = 1'b1;
        step();
        chk("d0_held_start_busy", int'(busy_v[0]), 1);
        repeat (20) step();
        start_v[0] = 1'b0;
        wait_done(0);

        repeat (3) step();
        chk("d0_sb_empty", sb_q[0].size(), 0);
        chk("d1_sb_empty", sb_q[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
